// File: rtl/led_pkg.sv
// Shared definitions for the LED frame buffer: default geometry, the GRB
// pixel layout and the streamer state encoding.
package led_pkg;

  // 5x5 matrix, index width matching the XY mapper, 24-bit GRB colour
  localparam int DEF_NUM_LEDS = 25;
  localparam int DEF_IDX_W    = 8;
  localparam int DEF_COLOR_W  = 24;

  // GRB pixel as the WS2812B expects it on the wire: G[7] is the MSB
  typedef struct packed {
    logic [7:0] g;
    logic [7:0] r;
    logic [7:0] b;
  } grb_t;

  // Streamer states; IDLE must stay 0 so busy is simply state != IDLE
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FETCH   = 2'd1,
    ST_PRESENT = 2'd2
  } stream_state_t;

  // Builds a packed GRB word from its three channels
  function automatic grb_t make_grb(input logic [7:0] g, input logic [7:0] r,
                                    input logic [7:0] b);
    grb_t c;
    c.g = g;
    c.r = r;
    c.b = b;
    return c;
  endfunction

endpackage

// File: rtl/led_frame_buffer_if.sv
// Bundle of the draw-side write port, the swap handshake and the
// serializer-side pixel stream. The frame buffer sits on the slave side;
// whoever draws and consumes pixels sits on the master side.
interface led_frame_buffer_if
  import led_pkg::*;
#(
  parameter int IDX_W   = DEF_IDX_W,
  parameter int COLOR_W = DEF_COLOR_W
);

  // draw side
  logic               wr_en;
  logic [IDX_W-1:0]   wr_idx;
  logic [COLOR_W-1:0] wr_color;

  // bank swap handshake
  logic               swap_req;
  logic               swap_ack;

  // serializer side
  logic               frame_start;
  logic               px_valid;
  logic               px_ready;
  logic [COLOR_W-1:0] px_color;
  logic               px_last;
  logic               busy;

  modport master (
    output wr_en, wr_idx, wr_color, swap_req, frame_start, px_ready,
    input  swap_ack, px_valid, px_color, px_last, busy
  );

  modport slave (
    input  wr_en, wr_idx, wr_color, swap_req, frame_start, px_ready,
    output swap_ack, px_valid, px_color, px_last, busy
  );

endinterface

// File: rtl/led_bank_ram.sv
// Two-bank pixel store: one write port, one synchronous read port with a
// single cycle of latency. The read register only updates when a read is
// issued, so its output holds while the pixel waits for the serializer.
// Contents are never reset.
module led_bank_ram #(
  parameter int DEPTH  = 50,
  parameter int ADDR_W = 6,
  parameter int DATA_W = 24
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Store a pixel from the draw side
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Registered read; holds its value between reads
  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/led_frame_buffer.sv
// Double-buffered pixel store between the XY mapper and the WS2812B
// serializer. Drawing writes go to the bank not on display; the display bank
// is streamed out in LED order over valid/ready. A swap request is held
// until the streamer is between frames, so a frame never mixes two banks.
module led_frame_buffer
  import led_pkg::*;
#(
  parameter int NUM_LEDS = DEF_NUM_LEDS,
  parameter int IDX_W    = DEF_IDX_W,
  parameter int COLOR_W  = DEF_COLOR_W
) (
  input  logic               clk,
  input  logic               rst,
  led_frame_buffer_if.slave  bus
);

  // Both banks live in one RAM, bank 1 starting right after bank 0
  localparam int              DEPTH     = 2 * NUM_LEDS;
  localparam int              ADDR_W    = $clog2(DEPTH);
  localparam logic [IDX_W-1:0] LED_COUNT = IDX_W'(NUM_LEDS);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_LEDS - 1);
  localparam logic [ADDR_W-1:0] BANK1_BASE = ADDR_W'(NUM_LEDS);

  stream_state_t      state;
  stream_state_t      next_state;
  logic [IDX_W-1:0]   rd_idx;
  logic [IDX_W-1:0]   next_rd_idx;

  logic               disp_sel;
  logic               swap_pending;
  logic               swap_ack_q;
  logic               swap_want;
  logic               swap_exec;
  logic               handshake;
  logic               last_handshake;

  logic               ram_wr_en;
  logic [ADDR_W-1:0]  ram_wr_addr;
  logic               ram_rd_en;
  logic [ADDR_W-1:0]  ram_rd_addr;
  logic [COLOR_W-1:0] ram_rd_data;

  led_bank_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (COLOR_W)
  ) u_ram (
    .clk     (clk),
    .wr_en   (ram_wr_en),
    .wr_addr (ram_wr_addr),
    .wr_data (bus.wr_color),
    .rd_en   (ram_rd_en),
    .rd_addr (ram_rd_addr),
    .rd_data (ram_rd_data)
  );

  // Draw-side writes: out-of-range indices are dropped, the rest land in the
  // bank that is not being displayed (as selected before any swap this edge)
  always_comb begin
    ram_wr_en   = bus.wr_en && (bus.wr_idx < LED_COUNT);
    ram_wr_addr = ADDR_W'(bus.wr_idx);
    if (!disp_sel) begin
      ram_wr_addr = BANK1_BASE + ADDR_W'(bus.wr_idx);
    end
  end

  // Streamer next-state logic and RAM read issue
  always_comb begin
    next_state     = state;
    next_rd_idx    = rd_idx;
    ram_rd_en      = 1'b0;
    ram_rd_addr    = disp_sel ? (BANK1_BASE + ADDR_W'(rd_idx)) : ADDR_W'(rd_idx);
    handshake      = (state == ST_PRESENT) && bus.px_ready;
    last_handshake = handshake && (rd_idx == LAST_IDX);
    case (state)
      ST_IDLE: begin
        if (bus.frame_start) begin
          next_rd_idx = '0;
          next_state  = ST_FETCH;
        end
      end
      ST_FETCH: begin
        ram_rd_en  = 1'b1;
        next_state = ST_PRESENT;
      end
      ST_PRESENT: begin
        if (handshake) begin
          if (rd_idx == LAST_IDX) begin
            next_state = ST_IDLE;
          end else begin
            next_rd_idx = rd_idx + IDX_W'(1);
            next_state  = ST_FETCH;
          end
        end
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  // Swap only when no frame is in flight: idle, or the edge that accepts the
  // last pixel; repeated requests before that collapse into one swap
  always_comb begin
    swap_want = swap_pending || bus.swap_req;
    swap_exec = swap_want && ((state == ST_IDLE) || last_handshake);
  end

  // Streamer state and read index; reset aborts any frame in progress
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      rd_idx <= '0;
    end else begin
      state  <= next_state;
      rd_idx <= next_rd_idx;
    end
  end

  // Bank select, pending swap and the one-cycle acknowledge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      disp_sel     <= 1'b0;
      swap_pending <= 1'b0;
      swap_ack_q   <= 1'b0;
    end else begin
      disp_sel     <= disp_sel ^ swap_exec;
      swap_pending <= swap_want && !swap_exec;
      swap_ack_q   <= swap_exec;
    end
  end

  // The RAM read register is the pixel register; it is masked outside
  // PRESENT so the stream reads as zero in idle and straight out of reset
  always_comb begin
    bus.px_valid = (state == ST_PRESENT);
    bus.px_last  = (state == ST_PRESENT) && (rd_idx == LAST_IDX);
    bus.px_color = (state == ST_PRESENT) ? ram_rd_data : '0;
    bus.busy     = (state != ST_IDLE);
    bus.swap_ack = swap_ack_q;
  end

endmodule

// File: tb/tb_led_frame_buffer.sv
// Directed bench for led_frame_buffer: reset state, ramp frame after a swap
// that carries the last pixel, mid-frame swap with draw-bank rewrite,
// ignored frame_start while busy, backpressure, out-of-range writes and a
// reset in the middle of a frame.
module tb_led_frame_buffer;
  import led_pkg::*;

  localparam int NUM_LEDS = 25;
  localparam int IDX_W    = 8;
  localparam int COLOR_W  = 24;

  logic clk = 1'b0;
  logic rst;
  int   check_count = 0;
  int   error_count = 0;
  int   frame_count = 0;

  always #5 clk = ~clk;

  led_frame_buffer_if #(.IDX_W(IDX_W), .COLOR_W(COLOR_W)) bus ();

  led_frame_buffer #(
    .NUM_LEDS (NUM_LEDS),
    .IDX_W    (IDX_W),
    .COLOR_W  (COLOR_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Each rising busy edge is one frame accepted by the DUT
  always @(posedge bus.busy) frame_count++;

  // Safety net in case something stalls beyond every bounded loop
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    check_count++;
    if (got !== exp) begin
      error_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One cycle of draw-side activity, then the strobes drop again
  task automatic applyStimulus(input logic en, input int idx,
                               input logic [23:0] color, input logic swap);
    bus.wr_en    = en;
    bus.wr_idx   = IDX_W'(idx);
    bus.wr_color = color;
    bus.swap_req = swap;
    tick();
    bus.wr_en    = 1'b0;
    bus.swap_req = 1'b0;
  endtask

  function automatic logic [23:0] rampColor(input int i);
    logic [23:0] v;
    v = 24'(i);
    return v * 24'h010101;
  endfunction

  // Streams one full frame and checks latency, order, px_last, frame length
  // and the swap acknowledge at the end
  task automatic runFrame(input string name, input int stall_idx,
                          input bit rewrite, input bit extra_start,
                          input bit exp_red, input bit exp_ack);
    logic [23:0] pix [NUM_LEDS];
    logic        lastf [NUM_LEDS];
    logic [23:0] held;
    logic [23:0] exp_c;
    int got;
    int cycles;
    int stall_cnt;
    int wr_k;
    int early_ack;
    int frames_before;
    got = 0; cycles = 0; stall_cnt = 0; wr_k = 0; early_ack = 0;
    held = '0;
    frames_before = frame_count;
    bus.px_ready    = 1'b1;
    bus.frame_start = 1'b1;
    tick();
    bus.frame_start = 1'b0;
    checkOutput({name, "_fetch_valid"}, 32'(bus.px_valid), 32'd0);
    checkOutput({name, "_fetch_busy"}, 32'(bus.busy), 32'd1);
    tick();
    checkOutput({name, "_first_valid"}, 32'(bus.px_valid), 32'd1);
    while (got < NUM_LEDS && cycles < 400) begin
      bus.wr_en = 1'b0; bus.swap_req = 1'b0; bus.frame_start = 1'b0;
      if (rewrite) begin
        if (wr_k < NUM_LEDS) begin
          bus.wr_en    = 1'b1;
          bus.wr_idx   = IDX_W'(wr_k);
          bus.wr_color = 24'hFF0000;
          wr_k++;
        end
        bus.swap_req = (cycles == 3 || cycles == 6);
      end
      if (extra_start) bus.frame_start = (cycles == 10 || cycles == 11);
      if (got == stall_idx && stall_cnt < 5 && (bus.px_valid || stall_cnt > 0)) begin
        bus.px_ready = 1'b0;
        if (stall_cnt == 0) begin
          held = bus.px_color;
        end else begin
          checkOutput({name, "_stall_valid"}, 32'(bus.px_valid), 32'd1);
          checkOutput({name, "_stall_color"}, 32'(bus.px_color), 32'(held));
        end
        stall_cnt++;
      end else begin
        bus.px_ready = 1'b1;
      end
      if (bus.px_valid && bus.px_ready) begin
        pix[got]   = bus.px_color;
        lastf[got] = bus.px_last;
        got++;
      end
      if (bus.swap_ack) early_ack++;
      tick();
      cycles++;
    end
    bus.wr_en = 1'b0; bus.swap_req = 1'b0; bus.frame_start = 1'b0;
    checkOutput({name, "_pixels"}, 32'(got), 32'(NUM_LEDS));
    checkOutput({name, "_cycles"}, 32'(cycles), (stall_idx >= 0) ? 32'd54 : 32'd49);
    checkOutput({name, "_end_busy"}, 32'(bus.busy), 32'd0);
    checkOutput({name, "_end_valid"}, 32'(bus.px_valid), 32'd0);
    checkOutput({name, "_end_ack"}, 32'(bus.swap_ack), 32'(exp_ack));
    checkOutput({name, "_early_ack"}, 32'(early_ack), 32'd0);
    for (int i = 0; i < got; i++) begin
      exp_c = exp_red ? 24'hFF0000 : rampColor(i);
      checkOutput($sformatf("%s_px%0d", name, i), 32'(pix[i]), 32'(exp_c));
      checkOutput($sformatf("%s_last%0d", name, i), 32'(lastf[i]), 32'(i == NUM_LEDS - 1));
    end
    tick();
    checkOutput({name, "_ack_clear"}, 32'(bus.swap_ack), 32'd0);
    checkOutput({name, "_idle_busy"}, 32'(bus.busy), 32'd0);
    checkOutput({name, "_frame_count"}, 32'(frame_count), 32'(frames_before + 1));
  endtask

  initial begin
    int got;
    int cycles;
    int ack_pulses;
    rst = 1'b1;
    bus.wr_en = 1'b0; bus.wr_idx = '0; bus.wr_color = '0;
    bus.swap_req = 1'b0; bus.frame_start = 1'b0; bus.px_ready = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_valid", 32'(bus.px_valid), 32'd0);
    checkOutput("rst_last", 32'(bus.px_last), 32'd0);
    checkOutput("rst_ack", 32'(bus.swap_ack), 32'd0);
    checkOutput("rst_busy", 32'(bus.busy), 32'd0);
    checkOutput("rst_color", 32'(bus.px_color), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    ack_pulses = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.swap_ack) ack_pulses++;
    end
    checkOutput("idle_ack_pulses", 32'(ack_pulses), 32'd0);
    checkOutput("idle_busy", 32'(bus.busy), 32'd0);

    // Ramp into the draw bank; the final pixel rides along with swap_req
    for (int i = 0; i < NUM_LEDS - 1; i++) applyStimulus(1'b1, i, rampColor(i), 1'b0);
    applyStimulus(1'b1, NUM_LEDS - 1, 24'h181818, 1'b1);
    checkOutput("swap_ack_pulse", 32'(bus.swap_ack), 32'd1);
    tick();
    checkOutput("swap_ack_single", 32'(bus.swap_ack), 32'd0);
    runFrame("ramp", -1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Swap requested mid-frame while the draw bank is rewritten to red
    runFrame("midswap", -1, 1'b1, 1'b0, 1'b0, 1'b1);
    runFrame("red", -1, 1'b0, 1'b1, 1'b1, 1'b0);

    // Back to the ramp bank, then out-of-range writes into the draw bank
    applyStimulus(1'b0, 0, 24'h0, 1'b1);
    checkOutput("swap2_ack", 32'(bus.swap_ack), 32'd1);
    applyStimulus(1'b1, 25, 24'h123456, 1'b0);
    checkOutput("swap2_ack_clear", 32'(bus.swap_ack), 32'd0);
    applyStimulus(1'b1, 200, 24'h654321, 1'b0);
    runFrame("oob_bp", 7, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset in the middle of a frame at index 12
    got = 0; cycles = 0;
    bus.px_ready = 1'b1;
    bus.frame_start = 1'b1;
    tick();
    bus.frame_start = 1'b0;
    while (!(bus.px_valid && got == 12) && cycles < 100) begin
      if (bus.px_valid) got++;
      tick();
      cycles++;
    end
    checkOutput("mid_reach_idx", 32'(got), 32'd12);
    checkOutput("mid_color12", 32'(bus.px_color), 32'h0C0C0C);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_valid", 32'(bus.px_valid), 32'd0);
    checkOutput("mid_rst_busy", 32'(bus.busy), 32'd0);
    checkOutput("mid_rst_last", 32'(bus.px_last), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    checkOutput("post_rst_busy", 32'(bus.busy), 32'd0);
    // Display bank is back to bank 0, which still holds the red frame
    runFrame("after_rst", -1, 1'b0, 1'b0, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule
